cpu_axi_arbiter: RTL and testbench

- Two-master to one-slave AXI3 arbiter between the instruction/data caches and the CPU's external AXI port.
- Slot 0 is the data cache and slot 1 is the instruction cache. Slave-side buses are packed {slot1, slot0}.
- At most one read burst and one write burst are outstanding at a time. Responses are routed by the registered grant, not by ID.

---
 rtl/cpu_axi_arbiter_pkg.sv | 32 +++
 rtl/cpu_axi_rr_pick2.sv | 21 ++
 rtl/cpu_axi_arbiter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cpu_axi_arbiter.sv | 587 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_arbiter_pkg.sv
// cpu_axi_arbiter shared definitions
// FSM states, slot ids, per-slot bus slicing
`ifndef AXI_ARB_SLICE
`define AXI_ARB_SLICE(bus, g, w) bus[(w)*int'(g) +: (w)]
`endif

package axi_arb_pkg;

  localparam logic SLOT_DCACHE = 1'b0;
  localparam logic SLOT_ICACHE = 1'b1;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } w_state_e;

endpackage

// File: rtl/cpu_axi_rr_pick2.sv
// cpu_axi_rr_pick2: two-way round-robin picker
// on a tie the slot not granted last wins
module cpu_axi_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // grant index from request pair and last winner
  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    unique case (req)
      2'b11:   gnt = ~last;
      2'b10:   gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter: dcache/icache to one AXI3 port
// one read and one write burst in flight at a time
module cpu_axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [2*ID_W-1:0]      s_arid,
  input  logic [2*ADDR_W-1:0]    s_araddr,
  input  logic [2*LEN_W-1:0]     s_arlen,
  input  logic [2*SIZE_W-1:0]    s_arsize,
  input  logic [2*BURST_W-1:0]   s_arburst,
  input  logic [2*LOCK_W-1:0]    s_arlock,
  input  logic [2*CACHE_W-1:0]   s_arcache,
  input  logic [2*PROT_W-1:0]    s_arprot,
  input  logic [1:0]             s_arvalid,
  output logic [1:0]             s_arready,
  output logic [2*ID_W-1:0]      s_rid,
  output logic [2*DATA_W-1:0]    s_rdata,
  output logic [2*RESP_W-1:0]    s_rresp,
  output logic [1:0]             s_rlast,
  output logic [1:0]             s_rvalid,
  input  logic [1:0]             s_rready,
  input  logic [2*ID_W-1:0]      s_awid,
  input  logic [2*ADDR_W-1:0]    s_awaddr,
  input  logic [2*LEN_W-1:0]     s_awlen,
  input  logic [2*SIZE_W-1:0]    s_awsize,
  input  logic [2*BURST_W-1:0]   s_awburst,
  input  logic [2*LOCK_W-1:0]    s_awlock,
  input  logic [2*CACHE_W-1:0]   s_awcache,
  input  logic [2*PROT_W-1:0]    s_awprot,
  input  logic [1:0]             s_awvalid,
  output logic [1:0]             s_awready,
  input  logic [2*ID_W-1:0]      s_wid,
  input  logic [2*DATA_W-1:0]    s_wdata,
  input  logic [2*(DATA_W/8)-1:0] s_wstrb,
  input  logic [1:0]             s_wlast,
  input  logic [1:0]             s_wvalid,
  output logic [1:0]             s_wready,
  output logic [2*ID_W-1:0]      s_bid,
  output logic [2*RESP_W-1:0]    s_bresp,
  output logic [1:0]             s_bvalid,
  input  logic [1:0]             s_bready,
  output logic [ID_W-1:0]        m_arid,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [LEN_W-1:0]       m_arlen,
  output logic [SIZE_W-1:0]      m_arsize,
  output logic [BURST_W-1:0]     m_arburst,
  output logic [LOCK_W-1:0]      m_arlock,
  output logic [CACHE_W-1:0]     m_arcache,
  output logic [PROT_W-1:0]      m_arprot,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [ID_W-1:0]        m_rid,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [RESP_W-1:0]      m_rresp,
  input  logic                   m_rlast,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  output logic [ID_W-1:0]        m_awid,
  output logic [ADDR_W-1:0]      m_awaddr,
  output logic [LEN_W-1:0]       m_awlen,
  output logic [SIZE_W-1:0]      m_awsize,
  output logic [BURST_W-1:0]     m_awburst,
  output logic [LOCK_W-1:0]      m_awlock,
  output logic [CACHE_W-1:0]     m_awcache,
  output logic [PROT_W-1:0]      m_awprot,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [ID_W-1:0]        m_wid,
  output logic [DATA_W-1:0]      m_wdata,
  output logic [DATA_W/8-1:0]    m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [ID_W-1:0]        m_bid,
  input  logic [RESP_W-1:0]      m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready
);

  localparam int STRB_W = DATA_W / 8;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic     r_gnt_q, r_gnt_d;
  logic     r_prev_q, r_prev_d;
  logic     w_gnt_q, w_gnt_d;
  logic     w_prev_q, w_prev_d;
  logic     aw_done_q, aw_done_d;
  logic     w_done_q, w_done_d;

  logic [1:0] r_req;
  logic       r_pick;
  logic       r_pick_vld;
  logic       w_pick;
  logic       w_pick_vld;
  logic       aw_hs;
  logic       w_hs;

  // dcache reads wait out any write in flight
  assign r_req[SLOT_ICACHE] = s_arvalid[SLOT_ICACHE];
  assign r_req[SLOT_DCACHE] = s_arvalid[SLOT_DCACHE]
                            & (w_state_q == W_IDLE);

  cpu_axi_rr_pick2 u_r_pick (
    .req   (r_req),
    .last  (r_prev_q),
    .gnt   (r_pick),
    .valid (r_pick_vld)
  );

  cpu_axi_rr_pick2 u_w_pick (
    .req   (s_awvalid),
    .last  (w_prev_q),
    .gnt   (w_pick),
    .valid (w_pick_vld)
  );

  // state registers for both channel FSMs
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= SLOT_DCACHE;
      r_prev_q  <= SLOT_ICACHE;
      w_state_q <= W_IDLE;
      w_gnt_q   <= SLOT_DCACHE;
      w_prev_q  <= SLOT_ICACHE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_gnt_q   <= r_gnt_d;
      r_prev_q  <= r_prev_d;
      w_state_q <= w_state_d;
      w_gnt_q   <= w_gnt_d;
      w_prev_q  <= w_prev_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // read FSM next state and AR/R routing
  always_comb begin
    r_state_d = r_state_q;
    r_gnt_d   = r_gnt_q;
    r_prev_d  = r_prev_q;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    m_arlock  = '0;
    m_arcache = '0;
    m_arprot  = '0;
    m_arvalid = 1'b0;
    s_arready = '0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (r_pick_vld) begin
          r_gnt_d   = r_pick;
          r_prev_d  = r_pick;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arid    = `AXI_ARB_SLICE(s_arid, r_gnt_q, ID_W);
        m_araddr  = `AXI_ARB_SLICE(s_araddr, r_gnt_q, ADDR_W);
        m_arlen   = `AXI_ARB_SLICE(s_arlen, r_gnt_q, LEN_W);
        m_arsize  = `AXI_ARB_SLICE(s_arsize, r_gnt_q, SIZE_W);
        m_arburst = `AXI_ARB_SLICE(s_arburst, r_gnt_q, BURST_W);
        m_arlock  = `AXI_ARB_SLICE(s_arlock, r_gnt_q, LOCK_W);
        m_arcache = `AXI_ARB_SLICE(s_arcache, r_gnt_q, CACHE_W);
        m_arprot  = `AXI_ARB_SLICE(s_arprot, r_gnt_q, PROT_W);
        m_arvalid = s_arvalid[r_gnt_q];
        s_arready[r_gnt_q] = m_arready;
        if (s_arvalid[r_gnt_q] && m_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        `AXI_ARB_SLICE(s_rid, r_gnt_q, ID_W)       = m_rid;
        `AXI_ARB_SLICE(s_rdata, r_gnt_q, DATA_W)   = m_rdata;
        `AXI_ARB_SLICE(s_rresp, r_gnt_q, RESP_W)   = m_rresp;
        s_rlast[r_gnt_q]  = m_rlast;
        s_rvalid[r_gnt_q] = m_rvalid;
        m_rready          = s_rready[r_gnt_q];
        if (m_rvalid && s_rready[r_gnt_q] && m_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (areset) begin
      m_arvalid = 1'b0;
      s_arready = '0;
      s_rvalid  = '0;
      m_rready  = 1'b0;
    end
  end

  assign aw_hs = !aw_done_q && s_awvalid[w_gnt_q] && m_awready;
  assign w_hs  = !w_done_q && s_wvalid[w_gnt_q] && m_wready
               && s_wlast[w_gnt_q];

  // write FSM next state and AW/W/B routing
  always_comb begin
    w_state_d = w_state_q;
    w_gnt_d   = w_gnt_q;
    w_prev_d  = w_prev_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    m_awlock  = '0;
    m_awcache = '0;
    m_awprot  = '0;
    m_awvalid = 1'b0;
    s_awready = '0;
    m_wid     = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_wvalid  = 1'b0;
    s_wready  = '0;
    s_bid     = '0;
    s_bresp   = '0;
    s_bvalid  = '0;
    m_bready  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_d   = w_pick;
          w_prev_d  = w_pick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_XFER;
        end
      end
      W_XFER: begin
        if (!aw_done_q) begin
          m_awid    = `AXI_ARB_SLICE(s_awid, w_gnt_q, ID_W);
          m_awaddr  = `AXI_ARB_SLICE(s_awaddr, w_gnt_q, ADDR_W);
          m_awlen   = `AXI_ARB_SLICE(s_awlen, w_gnt_q, LEN_W);
          m_awsize  = `AXI_ARB_SLICE(s_awsize, w_gnt_q, SIZE_W);
          m_awburst = `AXI_ARB_SLICE(s_awburst, w_gnt_q, BURST_W);
          m_awlock  = `AXI_ARB_SLICE(s_awlock, w_gnt_q, LOCK_W);
          m_awcache = `AXI_ARB_SLICE(s_awcache, w_gnt_q, CACHE_W);
          m_awprot  = `AXI_ARB_SLICE(s_awprot, w_gnt_q, PROT_W);
          m_awvalid = s_awvalid[w_gnt_q];
          s_awready[w_gnt_q] = m_awready;
        end
        if (!w_done_q) begin
          m_wid    = `AXI_ARB_SLICE(s_wid, w_gnt_q, ID_W);
          m_wdata  = `AXI_ARB_SLICE(s_wdata, w_gnt_q, DATA_W);
          m_wstrb  = `AXI_ARB_SLICE(s_wstrb, w_gnt_q, STRB_W);
          m_wlast  = s_wlast[w_gnt_q];
          m_wvalid = s_wvalid[w_gnt_q];
          s_wready[w_gnt_q] = m_wready;
        end
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        `AXI_ARB_SLICE(s_bid, w_gnt_q, ID_W)     = m_bid;
        `AXI_ARB_SLICE(s_bresp, w_gnt_q, RESP_W) = m_bresp;
        s_bvalid[w_gnt_q] = m_bvalid;
        m_bready          = s_bready[w_gnt_q];
        if (m_bvalid && s_bready[w_gnt_q]) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (areset) begin
      m_awvalid = 1'b0;
      s_awready = '0;
      m_wvalid  = 1'b0;
      s_wready  = '0;
      s_bvalid  = '0;
      m_bready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb_cpu_axi_arbiter: directed bench
// scenario tasks with hand-computed expectations
module tb_cpu_axi_arbiter;
  import axi_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic aclk = 1'b0;
  logic areset;

  logic [2*IW-1:0]      s_arid;
  logic [2*AW-1:0]      s_araddr;
  logic [2*LEN_W-1:0]   s_arlen;
  logic [2*SIZE_W-1:0]  s_arsize;
  logic [2*BURST_W-1:0] s_arburst;
  logic [2*LOCK_W-1:0]  s_arlock;
  logic [2*CACHE_W-1:0] s_arcache;
  logic [2*PROT_W-1:0]  s_arprot;
  logic [1:0]           s_arvalid;
  logic [1:0]           s_arready;
  logic [2*IW-1:0]      s_rid;
  logic [2*DW-1:0]      s_rdata;
  logic [2*RESP_W-1:0]  s_rresp;
  logic [1:0]           s_rlast;
  logic [1:0]           s_rvalid;
  logic [1:0]           s_rready;
  logic [2*IW-1:0]      s_awid;
  logic [2*AW-1:0]      s_awaddr;
  logic [2*LEN_W-1:0]   s_awlen;
  logic [2*SIZE_W-1:0]  s_awsize;
  logic [2*BURST_W-1:0] s_awburst;
  logic [2*LOCK_W-1:0]  s_awlock;
  logic [2*CACHE_W-1:0] s_awcache;
  logic [2*PROT_W-1:0]  s_awprot;
  logic [1:0]           s_awvalid;
  logic [1:0]           s_awready;
  logic [2*IW-1:0]      s_wid;
  logic [2*DW-1:0]      s_wdata;
  logic [2*(DW/8)-1:0]  s_wstrb;
  logic [1:0]           s_wlast;
  logic [1:0]           s_wvalid;
  logic [1:0]           s_wready;
  logic [2*IW-1:0]      s_bid;
  logic [2*RESP_W-1:0]  s_bresp;
  logic [1:0]           s_bvalid;
  logic [1:0]           s_bready;
  logic [IW-1:0]        m_arid;
  logic [AW-1:0]        m_araddr;
  logic [LEN_W-1:0]     m_arlen;
  logic [SIZE_W-1:0]    m_arsize;
  logic [BURST_W-1:0]   m_arburst;
  logic [LOCK_W-1:0]    m_arlock;
  logic [CACHE_W-1:0]   m_arcache;
  logic [PROT_W-1:0]    m_arprot;
  logic                 m_arvalid;
  logic                 m_arready;
  logic [IW-1:0]        m_rid;
  logic [DW-1:0]        m_rdata;
  logic [RESP_W-1:0]    m_rresp;
  logic                 m_rlast;
  logic                 m_rvalid;
  logic                 m_rready;
  logic [IW-1:0]        m_awid;
  logic [AW-1:0]        m_awaddr;
  logic [LEN_W-1:0]     m_awlen;
  logic [SIZE_W-1:0]    m_awsize;
  logic [BURST_W-1:0]   m_awburst;
  logic [LOCK_W-1:0]    m_awlock;
  logic [CACHE_W-1:0]   m_awcache;
  logic [PROT_W-1:0]    m_awprot;
  logic                 m_awvalid;
  logic                 m_awready;
  logic [IW-1:0]        m_wid;
  logic [DW-1:0]        m_wdata;
  logic [DW/8-1:0]      m_wstrb;
  logic                 m_wlast;
  logic                 m_wvalid;
  logic                 m_wready;
  logic [IW-1:0]        m_bid;
  logic [RESP_W-1:0]    m_bresp;
  logic                 m_bvalid;
  logic                 m_bready;

  cpu_axi_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_arlock  (s_arlock),
    .s_arcache (s_arcache),
    .s_arprot  (s_arprot),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_awid    (s_awid),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awsize  (s_awsize),
    .s_awburst (s_awburst),
    .s_awlock  (s_awlock),
    .s_awcache (s_awcache),
    .s_awprot  (s_awprot),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wid     (s_wid),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arlock  (m_arlock),
    .m_arcache (m_arcache),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_awid    (m_awid),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awsize  (m_awsize),
    .m_awburst (m_awburst),
    .m_awlock  (m_awlock),
    .m_awcache (m_awcache),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wid     (m_wid),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  always #5 aclk = ~aclk;

  int vec  = 0;
  int errs = 0;

  logic [14:0] vr;
  assign vr = {m_arvalid, s_arready, s_rvalid, m_rready,
               m_awvalid, s_awready, m_wvalid, s_wready,
               s_bvalid, m_bready};

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_inputs();
    s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_arlock = '0;
    s_arcache = '0; s_arprot = '0; s_arvalid = '0;
    s_rready = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0;
    s_awsize = '0; s_awburst = '0; s_awlock = '0;
    s_awcache = '0; s_awprot = '0; s_awvalid = '0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0;
    s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    areset = 1'b1;
    s_araddr = {32'h0000_2000, 32'h0000_1000};
    s_arvalid = 2'b11;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b1; m_bvalid = 1'b1;
    s_rready = 2'b11; s_bready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (vr !== 15'd0) begin
        errs++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, vr);
      end
    end
    areset = 1'b0;
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    #1;
    vec++;
    if (vr !== 15'd0 || m_araddr !== 32'd0) begin
      errs++;
      $display("FAIL reset_first: vr %h addr %h want 0 0", vr, m_araddr);
    end
    tick();
    vec++;
    if (m_arvalid !== 1'b1 || s_arready !== 2'b01) begin
      errs++;
      $display("FAIL reset_grant: arv %b ardy %b want 1 01",
               m_arvalid, s_arready);
    end
    vec++;
    if (m_araddr !== 32'h0000_1000) begin
      errs++;
      $display("FAIL reset_addr: got %h want 00001000", m_araddr);
    end
  endtask

  task automatic test_contention();
    int cnt0;
    int cnt1;
    int g;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    do_reset();
    cnt0 = 0;
    cnt1 = 0;
    s_araddr = {32'h0000_0200, 32'h0000_0100};
    s_arlen = {4'd3, 4'd3};
    s_arvalid = 2'b11;
    s_rready = 2'b11;
    m_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      exp_addr = (g == 1) ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      vec++;
      if (m_arvalid !== 1'b1 || s_arready !== 2'(1 << g)) begin
        errs++;
        $display("FAIL cont_grant[%0d]: arv %b ardy %b want 1 slot %0d",
                 k, m_arvalid, s_arready, g);
      end
      vec++;
      if (m_araddr !== exp_addr) begin
        errs++;
        $display("FAIL cont_addr[%0d]: got %h want %h",
                 k, m_araddr, exp_addr);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        exp_data = 32'(k * 16 + b);
        m_rvalid = 1'b1;
        m_rlast = (b == 3);
        m_rdata = exp_data;
        #1;
        if (s_rvalid[0]) cnt0++;
        if (s_rvalid[1]) cnt1++;
        vec++;
        if (s_rvalid !== 2'(1 << g) || s_rlast[g] !== (b == 3) ||
            s_rdata[DW*g +: DW] !== exp_data) begin
          errs++;
          $display("FAIL cont_beat[%0d.%0d]: rv %b last %b data %h want slot %0d %h",
                   k, b, s_rvalid, s_rlast, s_rdata, g, exp_data);
        end
        tick();
      end
      m_rvalid = 1'b0;
      m_rlast = 1'b0;
    end
    vec++;
    if (cnt0 != 8 || cnt1 != 8) begin
      errs++;
      $display("FAIL cont_count: got %0d/%0d want 8/8", cnt0, cnt1);
    end
  endtask

  task automatic test_write_order();
    do_reset();
    s_awaddr[0 +: AW] = 32'h0000_0300;
    s_awvalid = 2'b01;
    s_wdata[0 +: DW] = 32'h0000_cafe;
    s_wstrb = 8'h0f;
    s_wlast = 2'b01;
    s_wvalid = 2'b01;
    s_bready = 2'b01;
    tick();
    m_wready = 1'b1;
    #1;
    vec++;
    if (m_wvalid !== 1'b1 || s_wready !== 2'b01 ||
        m_wdata !== 32'h0000_cafe || m_awvalid !== 1'b1 ||
        s_awready !== 2'b00) begin
      errs++;
      $display("FAIL wr_w_first: wv %b wr %b wd %h awv %b awr %b",
               m_wvalid, s_wready, m_wdata, m_awvalid, s_awready);
    end
    tick();
    s_wvalid = 2'b00;
    m_wready = 1'b0;
    #1;
    vec++;
    if (m_wvalid !== 1'b0 || m_bready !== 1'b0) begin
      errs++;
      $display("FAIL wr_w_done: wv %b bready %b want 0 0",
               m_wvalid, m_bready);
    end
    tick();
    m_awready = 1'b1;
    #1;
    vec++;
    if (s_awready !== 2'b01 || m_awaddr !== 32'h0000_0300 ||
        m_bready !== 1'b0) begin
      errs++;
      $display("FAIL wr_aw: awr %b addr %h bready %b",
               s_awready, m_awaddr, m_bready);
    end
    tick();
    s_awvalid = 2'b00;
    m_awready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec++;
      if (m_bready !== 1'b1 || s_bvalid !== 2'b00) begin
        errs++;
        $display("FAIL wr_bwait[%0d]: bready %b bv %b want 1 00",
                 i, m_bready, s_bvalid);
      end
      tick();
    end
    m_bvalid = 1'b1;
    m_bresp = 2'b10;
    m_bid = 4'h5;
    #1;
    vec++;
    if (s_bvalid !== 2'b01 || s_bresp[1:0] !== 2'b10 ||
        s_bid[3:0] !== 4'h5) begin
      errs++;
      $display("FAIL wr_b: bv %b resp %b id %h want 01 10 5",
               s_bvalid, s_bresp, s_bid);
    end
    tick();
    m_bvalid = 1'b0;
    #1;
    vec++;
    if (s_bvalid !== 2'b00 || m_bready !== 1'b0) begin
      errs++;
      $display("FAIL wr_idle: bv %b bready %b want 00 0",
               s_bvalid, m_bready);
    end
  endtask

  task automatic test_raw_hold();
    do_reset();
    s_awvalid = 2'b01;
    s_wvalid = 2'b01;
    s_wlast = 2'b01;
    m_awready = 1'b1;
    m_wready = 1'b1;
    tick();
    tick();
    s_awvalid = 2'b00;
    s_wvalid = 2'b00;
    s_araddr = {32'h0000_0500, 32'h0000_0400};
    s_arvalid = 2'b11;
    s_bready = 2'b01;
    tick();
    vec++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_0500) begin
      errs++;
      $display("FAIL raw_icache: arv %b addr %h want 1 00000500",
               m_arvalid, m_araddr);
    end
    m_arready = 1'b1;
    tick();
    s_arvalid = 2'b01;
    m_arready = 1'b0;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    s_rready = 2'b10;
    #1;
    vec++;
    if (s_rvalid !== 2'b10) begin
      errs++;
      $display("FAIL raw_irdata: rv %b want 10", s_rvalid);
    end
    tick();
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (m_arvalid !== 1'b0) begin
        errs++;
        $display("FAIL raw_hold[%0d]: arv %b want 0", i, m_arvalid);
      end
    end
    m_bvalid = 1'b1;
    #1;
    vec++;
    if (s_bvalid !== 2'b01 || m_arvalid !== 1'b0) begin
      errs++;
      $display("FAIL raw_b: bv %b arv %b want 01 0", s_bvalid, m_arvalid);
    end
    tick();
    m_bvalid = 1'b0;
    #1;
    vec++;
    if (m_arvalid !== 1'b0) begin
      errs++;
      $display("FAIL raw_lat: arv %b want 0", m_arvalid);
    end
    tick();
    vec++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_0400) begin
      errs++;
      $display("FAIL raw_release: arv %b addr %h want 1 00000400",
               m_arvalid, m_araddr);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] rp;
    logic [23:0] vp;
    int beat;
    rp = 24'haaaaaa;
    vp = 24'b1111_0111_1101_1111_1011_1110;
    beat = 0;
    do_reset();
    s_araddr[AW +: AW] = 32'h0000_3000;
    s_arlen[LEN_W +: LEN_W] = 4'd3;
    s_arvalid = 2'b10;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      vec++;
      if (m_arvalid !== 1'b1 || s_arready !== 2'b00) begin
        errs++;
        $display("FAIL bp_arwait[%0d]: arv %b ardy %b want 1 00",
                 c, m_arvalid, s_arready);
      end
      tick();
    end
    m_arready = 1'b1;
    #1;
    vec++;
    if (s_arready !== 2'b10) begin
      errs++;
      $display("FAIL bp_ar: ardy %b want 10", s_arready);
    end
    tick();
    m_arready = 1'b0;
    s_arvalid = 2'b00;
    for (int c = 0; c < 24 && beat < 4; c++) begin
      s_rready = {rp[c], 1'b1};
      m_rvalid = vp[c];
      m_rdata = 32'h0000_00a0 + 32'(beat);
      m_rlast = (beat == 3);
      #1;
      vec++;
      if (m_rready !== rp[c] || s_rvalid !== {vp[c], 1'b0}) begin
        errs++;
        $display("FAIL bp_track[%0d]: rready %b rv %b want %b %b0",
                 c, m_rready, s_rvalid, rp[c], vp[c]);
      end
      if (vp[c] && rp[c]) begin
        vec++;
        if (s_rdata[DW +: DW] !== 32'h0000_00a0 + 32'(beat) ||
            s_rlast[1] !== (beat == 3)) begin
          errs++;
          $display("FAIL bp_beat[%0d]: data %h last %b", beat,
                   s_rdata[DW +: DW], s_rlast[1]);
        end
        beat++;
      end
      tick();
    end
    vec++;
    if (beat != 4) begin
      errs++;
      $display("FAIL bp_beats: got %0d want 4", beat);
    end
    m_rvalid = 1'b0;
    s_rready = 2'b11;
    #1;
    vec++;
    if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin
      errs++;
      $display("FAIL bp_idle: rready %b rv %b want 0 00",
               m_rready, s_rvalid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    s_araddr[0 +: AW] = 32'h0000_4000;
    s_arlen[0 +: LEN_W] = 4'd7;
    s_arvalid = 2'b01;
    s_awaddr[AW +: AW] = 32'h0000_5000;
    s_awvalid = 2'b10;
    tick();
    m_arready = 1'b1;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    s_rready = 2'b01;
    m_rvalid = 1'b1;
    m_rdata = 32'd1;
    tick();
    m_rdata = 32'd2;
    #1;
    vec++;
    if (s_rvalid !== 2'b01 || m_awvalid !== 1'b1) begin
      errs++;
      $display("FAIL mid_busy: rv %b awv %b want 01 1",
               s_rvalid, m_awvalid);
    end
    areset = 1'b1;
    #1;
    vec++;
    if (vr !== 15'd0) begin
      errs++;
      $display("FAIL mid_assert: got %h want 0", vr);
    end
    tick();
    areset = 1'b0;
    m_rvalid = 1'b0;
    s_araddr[AW +: AW] = 32'h0000_6000;
    s_arvalid = 2'b10;
    #1;
    vec++;
    if (vr !== 15'd0 || m_araddr !== 32'd0 || m_awaddr !== 32'd0) begin
      errs++;
      $display("FAIL mid_idle: vr %h ar %h aw %h want 0 0 0",
               vr, m_araddr, m_awaddr);
    end
    tick();
    vec++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_6000) begin
      errs++;
      $display("FAIL mid_rgrant: arv %b addr %h want 1 00006000",
               m_arvalid, m_araddr);
    end
    vec++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 32'h0000_5000) begin
      errs++;
      $display("FAIL mid_wgrant: awv %b addr %h want 1 00005000",
               m_awvalid, m_awaddr);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_order();
    test_raw_hold();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
